// File: rtl/rv32_wb_arbiter_if.sv
// rtl/rv32_wb_arbiter_if.sv - register-file write-port arbitration bus (pipe, mul/div, FPU, writeback)
interface rv32_wb_arbiter_if #(
    parameter int XLEN = 32
);
    logic            pipe_valid_i;
    logic [4:0]      pipe_rd_i;
    logic [XLEN-1:0] pipe_result_i;
    logic            pipe_stall_o;

    logic            md_valid_i;
    logic [4:0]      md_rd_i;
    logic [XLEN-1:0] md_result_i;
    logic            md_ready_o;

    logic            fpu_valid_i;
    logic [4:0]      fpu_rd_i;
    logic [XLEN-1:0] fpu_result_i;
    logic            fpu_ready_o;

    logic            wb_en_o;
    logic [4:0]      wb_rd_o;
    logic [XLEN-1:0] wb_data_o;
    logic [1:0]      wb_src_o;

    // Producer / consumer side
    modport master (
        output pipe_valid_i, pipe_rd_i, pipe_result_i,
        input  pipe_stall_o,
        output md_valid_i, md_rd_i, md_result_i,
        input  md_ready_o,
        output fpu_valid_i, fpu_rd_i, fpu_result_i,
        input  fpu_ready_o,
        input  wb_en_o, wb_rd_o, wb_data_o, wb_src_o
    );

    // Arbiter side
    modport slave (
        input  pipe_valid_i, pipe_rd_i, pipe_result_i,
        output pipe_stall_o,
        input  md_valid_i, md_rd_i, md_result_i,
        output md_ready_o,
        input  fpu_valid_i, fpu_rd_i, fpu_result_i,
        output fpu_ready_o,
        output wb_en_o, wb_rd_o, wb_data_o, wb_src_o
    );
endinterface

// File: rtl/rv32_wb_arbiter.sv
// rtl/rv32_wb_arbiter.sv - regfile write-port arbiter: pipe vs held mul/div and FPU results
// Optional stall counter output perf_stall_cnt_o under RV32_WB_ARB_PERF_EN.
module rv32_wb_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int XLEN         = 32
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    rv32_wb_arbiter_if.slave    bus
`ifdef RV32_WB_ARB_PERF_EN
    ,
    output logic [31:0]         perf_stall_cnt_o
`endif
);
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        SRC_PIPE = 2'b00,
        SRC_MD   = 2'b01,
        SRC_FPU  = 2'b10,
        SRC_NONE = 2'b11
    } src_e;

    logic            md_hold_valid;
    logic [4:0]      md_hold_rd;
    logic [XLEN-1:0] md_hold_data;
    logic [CNT_W-1:0] md_starve;

    logic            fpu_hold_valid;
    logic [4:0]      fpu_hold_rd;
    logic [XLEN-1:0] fpu_hold_data;
    logic [CNT_W-1:0] fpu_starve;

    logic            rr_fpu;
    src_e            grant;
    logic            md_starved;
    logic            fpu_starved;
    logic            md_accept;
    logic            fpu_accept;
    logic [4:0]      sel_rd;
    logic [XLEN-1:0] sel_data;

    assign md_starved  = md_hold_valid  && (md_starve  == LIMIT);
    assign fpu_starved = fpu_hold_valid && (fpu_starve == LIMIT);
    assign md_accept   = bus.md_valid_i  && !md_hold_valid;
    assign fpu_accept  = bus.fpu_valid_i && !fpu_hold_valid;

    // Ready depends only on hold occupancy, never on this cycle's grant.
    assign bus.md_ready_o   = ~md_hold_valid;
    assign bus.fpu_ready_o  = ~fpu_hold_valid;
    assign bus.pipe_stall_o = bus.pipe_valid_i && (grant != SRC_PIPE);

    always_comb begin
        grant = SRC_NONE;
        if (md_starved && fpu_starved) begin
            grant = rr_fpu ? SRC_FPU : SRC_MD;
        end else if (md_starved) begin
            grant = SRC_MD;
        end else if (fpu_starved) begin
            grant = SRC_FPU;
        end else if (bus.pipe_valid_i) begin
            grant = SRC_PIPE;
        end else if (md_hold_valid && fpu_hold_valid) begin
            grant = rr_fpu ? SRC_FPU : SRC_MD;
        end else if (md_hold_valid) begin
            grant = SRC_MD;
        end else if (fpu_hold_valid) begin
            grant = SRC_FPU;
        end
    end

    always_comb begin
        sel_rd   = bus.pipe_rd_i;
        sel_data = bus.pipe_result_i;
        case (grant)
            SRC_MD: begin
                sel_rd   = md_hold_rd;
                sel_data = md_hold_data;
            end
            SRC_FPU: begin
                sel_rd   = fpu_hold_rd;
                sel_data = fpu_hold_data;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            md_hold_valid  <= 1'b0;
            md_hold_rd     <= '0;
            md_hold_data   <= '0;
            md_starve      <= '0;
            fpu_hold_valid <= 1'b0;
            fpu_hold_rd    <= '0;
            fpu_hold_data  <= '0;
            fpu_starve     <= '0;
            rr_fpu         <= 1'b0;
        end else begin
            if (grant == SRC_MD) begin
                md_hold_valid <= 1'b0;
            end else if (md_accept) begin
                md_hold_valid <= 1'b1;
                md_hold_rd    <= bus.md_rd_i;
                md_hold_data  <= bus.md_result_i;
            end
            if (grant == SRC_FPU) begin
                fpu_hold_valid <= 1'b0;
            end else if (fpu_accept) begin
                fpu_hold_valid <= 1'b1;
                fpu_hold_rd    <= bus.fpu_rd_i;
                fpu_hold_data  <= bus.fpu_result_i;
            end

            if (!md_hold_valid || grant == SRC_MD) begin
                md_starve <= '0;
            end else if (md_starve != LIMIT) begin
                md_starve <= md_starve + CNT_W'(1);
            end
            if (!fpu_hold_valid || grant == SRC_FPU) begin
                fpu_starve <= '0;
            end else if (fpu_starve != LIMIT) begin
                fpu_starve <= fpu_starve + CNT_W'(1);
            end

            // Round-robin pointer only moves on unit grants.
            if (grant == SRC_MD) begin
                rr_fpu <= 1'b1;
            end else if (grant == SRC_FPU) begin
                rr_fpu <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            bus.wb_en_o   <= 1'b0;
            bus.wb_rd_o   <= '0;
            bus.wb_data_o <= '0;
            bus.wb_src_o  <= 2'b00;
        end else if (grant != SRC_NONE) begin
            bus.wb_en_o   <= (sel_rd != 5'd0);
            bus.wb_rd_o   <= sel_rd;
            bus.wb_data_o <= sel_data;
            bus.wb_src_o  <= grant;
        end else begin
            bus.wb_en_o   <= 1'b0;
        end
    end

`ifdef RV32_WB_ARB_PERF_EN
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            perf_stall_cnt_o <= '0;
        end else if (bus.pipe_stall_o && (perf_stall_cnt_o != 32'hFFFF_FFFF)) begin
            perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rv32_wb_arbiter.sv
// tb/tb_rv32_wb_arbiter.sv - self-checking bench for rv32_wb_arbiter with a behavioural reference model
module tb_rv32_wb_arbiter;
    localparam int LIMIT = 4;

    logic clk;
    logic rst_n;
    bit   check_en;
    int   n_checks;
    int   n_err;

    rv32_wb_arbiter_if #(.XLEN(32)) bus ();
`ifdef RV32_WB_ARB_PERF_EN
    logic [31:0] perf_cnt;
`endif

    rv32_wb_arbiter #(.STARVE_LIMIT(LIMIT), .XLEN(32)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus.slave)
`ifdef RV32_WB_ARB_PERF_EN
        ,
        .perf_stall_cnt_o (perf_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: unit 0 = mul/div, unit 1 = FPU; age counts cycles lost, unbounded.
    bit          m_v[2];
    bit [4:0]    m_rd[2];
    bit [31:0]   m_data[2];
    int          m_age[2];
    bit          m_rr_fpu;
    bit          e_en;
    bit [4:0]    e_rd;
    bit [31:0]   e_data;
    bit [1:0]    e_src;
    int          e_perf;

    // 0 none, 1 pipe, 2 mul/div, 3 FPU
    function automatic int pick();
        bit sm = m_v[0] && (m_age[0] >= LIMIT);
        bit sf = m_v[1] && (m_age[1] >= LIMIT);
        if (sm && sf)                 return m_rr_fpu ? 3 : 2;
        if (sm)                       return 2;
        if (sf)                       return 3;
        if (bus.pipe_valid_i === 1'b1) return 1;
        if (m_v[0] && m_v[1])         return m_rr_fpu ? 3 : 2;
        if (m_v[0])                   return 2;
        if (m_v[1])                   return 3;
        return 0;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_v      = '{0, 0};
            m_age    = '{0, 0};
            m_rr_fpu = 1'b0;
            e_en = 0; e_rd = 0; e_data = 0; e_src = 0; e_perf = 0;
        end else begin
            int  g;
            bit  acc_m, acc_f;
            g     = pick();
            acc_m = bus.md_valid_i && !m_v[0];
            acc_f = bus.fpu_valid_i && !m_v[1];
            if (bus.pipe_valid_i && g != 1) e_perf++;
            if (g == 0) begin
                e_en = 0;
            end else begin
                e_rd   = (g == 1) ? bus.pipe_rd_i     : m_rd[g-2];
                e_data = (g == 1) ? bus.pipe_result_i : m_data[g-2];
                e_en   = (e_rd != 0);
                e_src  = (g == 1) ? 2'd0 : 2'(g - 1);
            end
            for (int u = 0; u < 2; u++) begin
                if (m_v[u] && g != u + 2) m_age[u]++;
                else                      m_age[u] = 0;
                if (g == u + 2) m_v[u] = 0;
            end
            if (acc_m) begin m_v[0] = 1; m_rd[0] = bus.md_rd_i;  m_data[0] = bus.md_result_i;  end
            if (acc_f) begin m_v[1] = 1; m_rd[1] = bus.fpu_rd_i; m_data[1] = bus.fpu_result_i; end
            if (g >= 2) m_rr_fpu = (g == 2);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            int g;
            g = pick();
            chk("model_stall",     32'(bus.pipe_stall_o), 32'(bus.pipe_valid_i && g != 1));
            chk("model_md_ready",  32'(bus.md_ready_o),   32'(!m_v[0]));
            chk("model_fpu_ready", 32'(bus.fpu_ready_o),  32'(!m_v[1]));
            chk("model_wb_en",     32'(bus.wb_en_o),      32'(e_en));
            chk("model_wb_rd",     32'(bus.wb_rd_o),      32'(e_rd));
            chk("model_wb_data",   bus.wb_data_o,         e_data);
            chk("model_wb_src",    32'(bus.wb_src_o),     32'(e_src));
`ifdef RV32_WB_ARB_PERF_EN
            chk("model_perf",      perf_cnt,              32'(e_perf));
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic idle();
        bus.pipe_valid_i = 0; bus.md_valid_i = 0; bus.fpu_valid_i = 0;
    endtask

    task automatic drive_pipe(input logic [4:0] rd, input logic [31:0] d);
        bus.pipe_valid_i = 1; bus.pipe_rd_i = rd; bus.pipe_result_i = d;
    endtask

    task automatic drive_md(input logic [4:0] rd, input logic [31:0] d);
        bus.md_valid_i = 1; bus.md_rd_i = rd; bus.md_result_i = d;
    endtask

    task automatic drive_fpu(input logic [4:0] rd, input logic [31:0] d);
        bus.fpu_valid_i = 1; bus.fpu_rd_i = rd; bus.fpu_result_i = d;
    endtask

    initial begin
        n_checks = 0; n_err = 0; check_en = 0;
        rst_n = 0;
        idle();
        bus.pipe_rd_i = 0; bus.pipe_result_i = 0;
        bus.md_rd_i = 0;   bus.md_result_i = 0;
        bus.fpu_rd_i = 0;  bus.fpu_result_i = 0;
        tick(); tick();
        rst_n = 1;
        check_en = 1;
        at_neg();
        chk("reset_wb_en", 32'(bus.wb_en_o), 0);
        chk("reset_md_ready", 32'(bus.md_ready_o), 1);

        // Pipe only
        tick(); drive_pipe(5'd5, 32'h1234);
        at_neg(); chk("pipe_stall", 32'(bus.pipe_stall_o), 0);
        tick(); idle();
        at_neg();
        chk("pipe_wb_en", 32'(bus.wb_en_o), 1);
        chk("pipe_wb_rd", 32'(bus.wb_rd_o), 5);
        chk("pipe_wb_data", bus.wb_data_o, 32'h1234);
        chk("pipe_wb_src", 32'(bus.wb_src_o), 0);

        // Both units offered with an idle pipe
        tick(); drive_md(5'd3, 32'hAAAA); drive_fpu(5'd4, 32'hBBBB);
        at_neg();
        chk("both_md_ready_pre", 32'(bus.md_ready_o), 1);
        chk("both_fpu_ready_pre", 32'(bus.fpu_ready_o), 1);
        tick(); idle();
        at_neg();
        chk("both_md_ready_held", 32'(bus.md_ready_o), 0);
        chk("both_fpu_ready_held", 32'(bus.fpu_ready_o), 0);
        tick(); at_neg();
        chk("both_first_rd", 32'(bus.wb_rd_o), 3);
        chk("both_first_src", 32'(bus.wb_src_o), 1);
        chk("both_first_data", bus.wb_data_o, 32'hAAAA);
        tick(); at_neg();
        chk("both_second_rd", 32'(bus.wb_rd_o), 4);
        chk("both_second_src", 32'(bus.wb_src_o), 2);
        chk("both_md_ready_post", 32'(bus.md_ready_o), 1);
        chk("both_fpu_ready_post", 32'(bus.fpu_ready_o), 1);

        // mul/div starvation under a continuous pipe
        tick(); drive_pipe(5'd9, 32'h99); drive_md(5'd7, 32'h77);
        tick(); bus.md_valid_i = 0;
        for (int i = 0; i < 4; i++) begin
            at_neg(); chk("starve_md_pipe_wins", 32'(bus.pipe_stall_o), 0);
            tick();
        end
        at_neg(); chk("starve_md_stall", 32'(bus.pipe_stall_o), 1);
        tick(); at_neg();
        chk("starve_md_granted_src", 32'(bus.wb_src_o), 1);
        chk("starve_md_granted_rd", 32'(bus.wb_rd_o), 7);
        chk("starve_md_after_stall", 32'(bus.pipe_stall_o), 0);
        tick(); idle(); at_neg();
        chk("starve_md_pipe_again_src", 32'(bus.wb_src_o), 0);
        chk("starve_md_pipe_again_rd", 32'(bus.wb_rd_o), 9);

        tick(); rst_n = 0;
        tick(); rst_n = 1;

        // Both units starved
        tick(); drive_pipe(5'd10, 32'h10); drive_md(5'd11, 32'h11); drive_fpu(5'd12, 32'h12);
        tick(); bus.md_valid_i = 0; bus.fpu_valid_i = 0;
        repeat (4) tick();
        at_neg(); chk("starve2_stall_a", 32'(bus.pipe_stall_o), 1);
        tick(); at_neg();
        chk("starve2_stall_b", 32'(bus.pipe_stall_o), 1);
        chk("starve2_first_src", 32'(bus.wb_src_o), 1);
        chk("starve2_first_rd", 32'(bus.wb_rd_o), 11);
        tick(); idle(); at_neg();
        chk("starve2_second_src", 32'(bus.wb_src_o), 2);
        chk("starve2_second_rd", 32'(bus.wb_rd_o), 12);

        // rd == 0 from mul/div
        tick(); drive_md(5'd0, 32'h55);
        tick(); idle(); at_neg();
        chk("rd0_md_ready_held", 32'(bus.md_ready_o), 0);
        tick(); at_neg();
        chk("rd0_wb_en", 32'(bus.wb_en_o), 0);
        chk("rd0_wb_src", 32'(bus.wb_src_o), 1);
        chk("rd0_wb_data", bus.wb_data_o, 32'h55);
        chk("rd0_md_ready", 32'(bus.md_ready_o), 1);

        // Reset while both holds are full and the pipe is stalled
        tick(); drive_pipe(5'd13, 32'h13); drive_md(5'd14, 32'h14); drive_fpu(5'd15, 32'h15);
        tick(); bus.md_valid_i = 0; bus.fpu_valid_i = 0;
        repeat (4) tick();
        rst_n = 0;
        at_neg(); chk("rst_pre_stall", 32'(bus.pipe_stall_o), 1);
        tick(); rst_n = 1; idle(); at_neg();
        chk("rst_wb_en", 32'(bus.wb_en_o), 0);
        chk("rst_wb_rd", 32'(bus.wb_rd_o), 0);
        chk("rst_wb_data", bus.wb_data_o, 0);
        chk("rst_wb_src", 32'(bus.wb_src_o), 0);
        chk("rst_md_ready", 32'(bus.md_ready_o), 1);
        chk("rst_fpu_ready", 32'(bus.fpu_ready_o), 1);
`ifdef RV32_WB_ARB_PERF_EN
        chk("rst_perf", perf_cnt, 0);
`endif
        tick(); tick();
        check_en = 0;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
